icache_fetch_port: RTL and testbench

Direct-mapped instruction cache serving the instruction fetcher's single combinational lookup port. Each cycle it returns the instruction at the fetcher's halfword-aligned PC, including 32-bit instructions that straddle two words or two lines. On a miss it refills the whole line, one word at a time, from the memory controller. Sits between the fetcher (downstream) and the memory controller (upstream).

---
 rtl/icache_fetch_port_pkg.sv | 18 +
 rtl/icache_fetch_port_line_store.sv | 66 ++++++
 rtl/icache_fetch_port.sv | 124 ++++++++++++
 tb/tb_icache_fetch_port.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_fetch_port_pkg.sv
// rtl/icache_fetch_port_pkg.sv - shared widths, FSM encodings and helpers for the fetch-port icache
package icache_fetch_port_pkg;

    localparam int ICACHE_INDEX_WIDTH  = 5;
    localparam int ICACHE_OFFSET_WIDTH = 2;
    localparam int ICACHE_TAG_WIDTH    = 32 - ICACHE_INDEX_WIDTH - ICACHE_OFFSET_WIDTH - 2;

    typedef enum logic {
        IC_IDLE   = 1'b0,
        IC_REFILL = 1'b1
    } ic_state_e;

    // RISC-V: a parcel whose low two bits are not 2'b11 is a 16-bit instruction
    function automatic logic is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/icache_fetch_port_line_store.sv
// rtl/icache_fetch_port_line_store.sv - direct-mapped tag/valid/data arrays with two word read ports
module icache_fetch_port_line_store #(
    parameter int INDEX_WIDTH  = 5,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [29:0]                rd0_addr_i,
    output logic [31:0]                rd0_word_o,
    output logic                       rd0_hit_o,
    input  logic [29:0]                rd1_addr_i,
    output logic [31:0]                rd1_word_o,
    output logic                       rd1_hit_o,
    input  logic                       wr_en_i,
    input  logic [29-OFFSET_WIDTH:0]   wr_line_i,
    input  logic [OFFSET_WIDTH-1:0]    wr_off_i,
    input  logic [31:0]                wr_word_i,
    input  logic                       wr_last_i
);

    localparam int TAG_W = 30 - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int LINES = 2 ** INDEX_WIDTH;
    localparam int WORDS = 2 ** (INDEX_WIDTH + OFFSET_WIDTH);

    logic [31:0]      data_q [WORDS];
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [LINES-1:0] valid_q;

    logic [INDEX_WIDTH-1:0] wr_idx;
    assign wr_idx = wr_line_i[INDEX_WIDTH-1:0];

    logic [INDEX_WIDTH-1:0]  rd0_idx, rd1_idx;
    logic [OFFSET_WIDTH-1:0] rd0_off, rd1_off;
    logic [TAG_W-1:0]        rd0_tag, rd1_tag;

    assign rd0_idx = rd0_addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign rd1_idx = rd1_addr_i[OFFSET_WIDTH +: INDEX_WIDTH];
    assign rd0_off = rd0_addr_i[OFFSET_WIDTH-1:0];
    assign rd1_off = rd1_addr_i[OFFSET_WIDTH-1:0];
    assign rd0_tag = rd0_addr_i[29 -: TAG_W];
    assign rd1_tag = rd1_addr_i[29 -: TAG_W];

    assign rd0_word_o = data_q[{rd0_idx, rd0_off}];
    assign rd1_word_o = data_q[{rd1_idx, rd1_off}];
    assign rd0_hit_o  = valid_q[rd0_idx] && (tag_q[rd0_idx] == rd0_tag);
    assign rd1_hit_o  = valid_q[rd1_idx] && (tag_q[rd1_idx] == rd1_tag);

    // Only the valid bits are reset; stale tag/data are harmless while invalid
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i && wr_last_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[{wr_idx, wr_off_i}] <= wr_word_i;
            if (wr_last_i) begin
                tag_q[wr_idx] <= wr_line_i[29-OFFSET_WIDTH -: TAG_W];
            end
        end
    end

endmodule

// File: rtl/icache_fetch_port.sv
// rtl/icache_fetch_port.sv - direct-mapped icache with straddle-aware fetch port and line refill FSM
module icache_fetch_port
    import icache_fetch_port_pkg::*;
#(
    parameter int INDEX_WIDTH  = ICACHE_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = ICACHE_OFFSET_WIDTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_enable_in,
    input  logic [31:0] pc_in,
    output logic        ic_valid_out,
    output logic [31:0] ic_instr_out,
    output logic        ic2mc_req_out,
    output logic [31:0] ic2mc_addr_out,
    input  logic        mc2ic_ready_in,
    input  logic [31:0] mc2ic_word_in
);

    localparam int LINE_W = 30 - OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] K_LAST = '1;
    localparam logic [OFFSET_WIDTH-1:0] K_ONE  = OFFSET_WIDTH'(1);

    logic [29:0] w0_addr, w1_addr;
    logic [31:0] w0_word, w1_word;
    logic        w0_hit, w1_hit;

    assign w0_addr = pc_in[31:2];
    assign w1_addr = w0_addr + 30'd1;

    ic_state_e             state_q;
    logic [OFFSET_WIDTH-1:0] k_q;
    logic                  req_q;
    logic [31:0]           addr_q;
    logic [LINE_W-1:0]     line_q;

    logic wr_en;
    assign wr_en = rdy_in && (state_q == IC_REFILL) && mc2ic_ready_in;

    icache_fetch_port_line_store #(
        .INDEX_WIDTH  (INDEX_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_store (
        .clk_i      (clk_in),
        .rst_ni     (rst_in),
        .rd0_addr_i (w0_addr),
        .rd0_word_o (w0_word),
        .rd0_hit_o  (w0_hit),
        .rd1_addr_i (w1_addr),
        .rd1_word_o (w1_word),
        .rd1_hit_o  (w1_hit),
        .wr_en_i    (wr_en),
        .wr_line_i  (line_q),
        .wr_off_i   (k_q),
        .wr_word_i  (mc2ic_word_in),
        .wr_last_i  (k_q == K_LAST)
    );

    logic [15:0] lo_half;
    logic        compressed;
    logic        need_w1;
    logic        hit;

    always_comb begin
        lo_half      = pc_in[1] ? w0_word[31:16] : w0_word[15:0];
        compressed   = is_compressed(lo_half);
        need_w1      = pc_in[1] && !compressed;
        hit          = w0_hit && (!need_w1 || w1_hit);
        ic_instr_out = w0_word;
        if (compressed) begin
            ic_instr_out = {16'h0000, lo_half};
        end else if (pc_in[1]) begin
            ic_instr_out = {w1_word[15:0], lo_half};
        end
    end

    assign ic_valid_out = fetch_enable_in && (state_q == IC_IDLE) && hit;

    // w0's line takes priority; w1's line is only fetched once w0 is resident
    logic [LINE_W-1:0] refill_line;
    assign refill_line = w0_hit ? w1_addr[29:OFFSET_WIDTH] : w0_addr[29:OFFSET_WIDTH];

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IC_IDLE;
            k_q     <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            line_q  <= '0;
        end else if (rdy_in) begin
            case (state_q)
                IC_IDLE: begin
                    if (fetch_enable_in && !hit) begin
                        line_q  <= refill_line;
                        k_q     <= '0;
                        req_q   <= 1'b1;
                        addr_q  <= {refill_line, {OFFSET_WIDTH{1'b0}}, 2'b00};
                        state_q <= IC_REFILL;
                    end
                end
                IC_REFILL: begin
                    if (mc2ic_ready_in) begin
                        if (k_q == K_LAST) begin
                            req_q   <= 1'b0;
                            state_q <= IC_IDLE;
                        end else begin
                            k_q    <= k_q + K_ONE;
                            addr_q <= {line_q, k_q + K_ONE, 2'b00};
                        end
                    end
                end
                default: state_q <= IC_IDLE;
            endcase
        end
    end

    assign ic2mc_req_out  = req_q;
    assign ic2mc_addr_out = addr_q;

    logic [16:0] unused_bits;
    assign unused_bits = {pc_in[0], w1_word[31:16]};

endmodule

// File: tb/tb_icache_fetch_port.sv
// tb/tb_icache_fetch_port.sv - directed bench with resident-line model for icache_fetch_port
module tb_icache_fetch_port;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        fetch_enable_in = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        ic_valid_out;
    logic [31:0] ic_instr_out;
    logic        ic2mc_req_out;
    logic [31:0] ic2mc_addr_out;
    logic        mc2ic_ready_in = 1'b0;
    logic [31:0] mc2ic_word_in = 32'h0;

    icache_fetch_port dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .fetch_enable_in (fetch_enable_in),
        .pc_in           (pc_in),
        .ic_valid_out    (ic_valid_out),
        .ic_instr_out    (ic_instr_out),
        .ic2mc_req_out   (ic2mc_req_out),
        .ic2mc_addr_out  (ic2mc_addr_out),
        .mc2ic_ready_in  (mc2ic_ready_in),
        .mc2ic_word_in   (mc2ic_word_in)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:127];
    logic [31:0] req_log [$];

    // model: which 16-byte line number is resident in each slot, and refill progress
    bit          res_v    [32];
    logic [27:0] res_line [32];
    bit          m_busy = 1'b0;
    logic [27:0] m_line = '0;
    int          m_cnt  = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a < 32'd512) return mem[a[8:2]];
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic bit resident(input logic [27:0] l);
        return res_v[l[4:0]] && (res_line[l[4:0]] == l);
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory controller: 2 cycles per word, frozen by rdy_in, reset by rst_in
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (!rst_in) begin
                mc2ic_ready_in = 1'b0;
                cnt = 0;
            end else if (!rdy_in) begin
                cnt = cnt;
            end else if (mc2ic_ready_in) begin
                mc2ic_ready_in = 1'b0;
            end else if (ic2mc_req_out) begin
                cnt++;
                if (cnt == 2) begin
                    mc2ic_ready_in = 1'b1;
                    mc2ic_word_in  = mem_rd(ic2mc_addr_out);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // compare process: every cycle against the model, then advance the model
    initial begin
        logic [31:0] a0, a1, w0, w1, e_instr;
        logic [15:0] lo;
        bit comp, e_hit, e_valid;
        forever begin
            @(negedge clk_in);
            if (!rst_in) begin
                m_busy = 1'b0;
                m_cnt  = 0;
                for (int i = 0; i < 32; i++) res_v[i] = 1'b0;
            end
            a0 = {pc_in[31:2], 2'b00};
            a1 = a0 + 32'd4;
            w0 = mem_rd(a0);
            w1 = mem_rd(a1);
            lo = pc_in[1] ? w0[31:16] : w0[15:0];
            comp = (lo[1:0] != 2'b11);
            e_instr = comp ? {16'h0, lo} : (pc_in[1] ? {w1[15:0], lo} : w0);
            e_hit = resident(a0[31:4]) && (comp || !pc_in[1] || resident(a1[31:4]));
            e_valid = fetch_enable_in && !m_busy && e_hit;
            check1("m_valid", ic_valid_out, e_valid);
            check1("m_req", ic2mc_req_out, m_busy);
            if (m_busy) check32("m_addr", ic2mc_addr_out, {m_line, m_cnt[1:0], 2'b00});
            if (e_valid && ic_valid_out) check32("m_instr", ic_instr_out, e_instr);
            if (rst_in && rdy_in) begin
                if (!m_busy) begin
                    if (fetch_enable_in && !e_hit) begin
                        m_busy = 1'b1;
                        m_cnt  = 0;
                        m_line = resident(a0[31:4]) ? a1[31:4] : a0[31:4];
                    end
                end else if (mc2ic_ready_in) begin
                    req_log.push_back(ic2mc_addr_out);
                    m_cnt++;
                    if (m_cnt == 4) begin
                        res_v[m_line[4:0]]    = 1'b1;
                        res_line[m_line[4:0]] = m_line;
                        m_busy = 1'b0;
                        m_cnt  = 0;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_valid(input int maxc, input string name);
        int c;
        c = 0;
        while (c < maxc) begin
            @(negedge clk_in);
            #1;
            if (ic_valid_out) break;
            c++;
        end
        n_tests++;
        if (c >= maxc) begin
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, ic_valid_out=%b required 1", name, c, ic_valid_out);
        end
    endtask

    task automatic wait_log(input int n, input int maxc, input string name);
        int c;
        c = 0;
        while (c < maxc && req_log.size() < n) begin
            @(negedge clk_in);
            #1;
            c++;
        end
        n_tests++;
        if (req_log.size() < n) begin
            n_fail++;
            $display("FAIL %s: timeout, %0d responses seen, required %0d", name, req_log.size(), n);
        end
    endtask

    task automatic check_log(input int start, input logic [31:0] base, input string name);
        for (int i = 0; i < 4; i++) begin
            if (start + i < req_log.size())
                check32(name, req_log[start+i], base + 32'(4 * i));
            else
                check32(name, 32'hxxxxxxxx, base + 32'(4 * i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h9E3779B9 * i;
        mem[0]  = 32'h0000_0513;
        mem[1]  = 32'h4501_0010;
        mem[2]  = 32'h1111_2222;
        mem[3]  = 32'h0793_0001;
        mem[4]  = 32'hABCD_0037;
        mem[64] = 32'h00A0_0093;

        fetch_enable_in = 1'b1;
        pc_in = 32'h0;
        repeat (2) @(negedge clk_in);
        #1;
        check1("reset_req", ic2mc_req_out, 1'b0);
        check32("reset_addr", ic2mc_addr_out, 32'h0);
        check1("reset_valid", ic_valid_out, 1'b0);
        step();
        rst_in = 1'b1;
        req_log.delete();

        wait_valid(60, "cold_miss");
        check32("cold_instr", ic_instr_out, 32'h0000_0513);
        check32("cold_nreq", 32'(req_log.size()), 32'd4);
        check_log(0, 32'h0, "cold_reqs");

        step();
        pc_in = 32'h6;
        @(negedge clk_in); #1;
        check1("comp_valid", ic_valid_out, 1'b1);
        check32("comp_instr", ic_instr_out, 32'h0000_4501);

        step();
        pc_in = 32'hE;
        req_log.delete();
        @(negedge clk_in); #1;
        check1("straddle_miss", ic_valid_out, 1'b0);
        wait_valid(60, "straddle_fill");
        check32("straddle_instr", ic_instr_out, 32'h0037_0793);
        check_log(0, 32'h10, "straddle_reqs");

        step();
        req_log.delete();
        pc_in = 32'h20;
        repeat (4) step();
        fetch_enable_in = 1'b0;
        pc_in = 32'h100;
        repeat (3) step();
        fetch_enable_in = 1'b1;
        wait_valid(100, "jump_fill");
        check32("jump_instr", ic_instr_out, 32'h00A0_0093);
        check32("jump_nreq", 32'(req_log.size()), 32'd8);
        check_log(0, 32'h20, "jump_old_line");
        check_log(4, 32'h100, "jump_new_line");

        step();
        req_log.delete();
        pc_in = 32'h40;
        wait_log(1, 40, "rdy_first_word");
        step();
        rdy_in = 1'b0;
        repeat (5) begin
            @(negedge clk_in); #1;
            check32("rdy_hold_addr", ic2mc_addr_out, 32'h44);
            check1("rdy_hold_req", ic2mc_req_out, 1'b1);
        end
        step();
        rdy_in = 1'b1;
        wait_valid(60, "rdy_resume");
        check32("rdy_nreq", 32'(req_log.size()), 32'd4);
        check_log(0, 32'h40, "rdy_reqs");

        step();
        req_log.delete();
        pc_in = 32'h30;
        wait_log(2, 40, "rst_two_words");
        step();
        rst_in = 1'b0;
        #1;
        check1("rst_mid_req", ic2mc_req_out, 1'b0);
        check1("rst_mid_valid", ic_valid_out, 1'b0);
        step();
        step();
        rst_in = 1'b1;
        req_log.delete();
        wait_valid(60, "rst_refetch");
        check32("rst_nreq", 32'(req_log.size()), 32'd4);
        check_log(0, 32'h30, "rst_reqs");

        step();
        mem[0] = 32'h0593_0513;
        pc_in = 32'h2;
        wait_valid(60, "upper_fill");
        check32("upper_instr", ic_instr_out, 32'h0010_0593);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
